f1_start_seq: RTL
=================

# f1_start_seq

Parametrised F1 start-light sequencer: fills a bar of `N_LIGHTS` lamps one per tick, holds all-on for a programmable delay, switches all lamps off, then measures driver reaction time in ticks. It flags jump starts and timeouts. It sits between the tick generator (`en` strobe), the delay source (e.g. the LFSR) and the LED/7-seg display logic. It replaces the fixed 8-light sequencer and removes the external delay handshake.

## Interface
- `N_LIGHTS`, default 8: number of lamps; ≥ 2.
- `DELAY_W`, default 7: width of hold-delay value.
- `REACT_W`, default 12: width of reaction counter.
- `clk`  in  1: system clock; one clock, all logic on rising edge.
- `rst`  in  1: reset is asynchronous and active-low (asserted when 0).
- `en`  in  1: one-cycle tick strobe; all sequencing advances only on `en`.
- `trigger`  in  1: start request, sampled every clock.
- `delay_val`  in  DELAY_W: hold delay in ticks, latched when a start is accepted.
- `react`  in  1: driver response, level, sampled every clock.
- `dout`  out  N_LIGHTS: lamp bar, bit 0 lit first.
- `busy`  out  1: high in FILL, HOLD, OUT.
- `lights_out`  out  1: one-cycle pulse on entry to OUT.
- `react_valid`  out  1: one-cycle pulse on entry to DONE.
- `react_time`  out  REACT_W: measured ticks, held in DONE.
- `jump_start`  out  1: level, held in DONE.
- `timeout`  out  1: level, held in DONE.

## Operation
- States: IDLE, FILL, HOLD, OUT, DONE.
- IDLE: `dout`=0. If `trigger`=1, go to FILL, set `light_cnt`=1 and latch `delay_val` into `hold_cnt`.
- FILL: `dout` has the low `light_cnt` bits set.
  - On `en` with `light_cnt`<N_LIGHTS: increment `light_cnt`.
  - On `en` with `light_cnt`=N_LIGHTS: go to HOLD.
- HOLD: `dout`=all ones. On `en`: if `hold_cnt`=0, go to OUT; otherwise decrement `hold_cnt`. `delay_val`=0 is legal.
- OUT: `dout`=0. `react_cnt` is cleared on entry and incremented on each `en`.
  - If `react`=1: go to DONE with `react_time`=current `react_cnt`, which is the value before any same-cycle increment.
  - If `react_cnt` is at max (2^REACT_W−1) and `en`=1: go to DONE with `timeout`=1 and `react_time`=max.
- Jump start: `react`=1 in FILL or HOLD sends the block to DONE with `jump_start`=1, `react_time`=0 and `dout`=0. This takes priority over a same-cycle `en` or HOLD expiry.
- DONE: results and flags are held. `trigger`=1 clears `react_time`, `jump_start` and `timeout`, then starts a new run exactly as from IDLE.
- `trigger` is ignored in FILL, HOLD and OUT.
- Reset, including mid-run: state=IDLE, all counters 0, all outputs 0, immediately and asynchronously.

## Timing
- Start accepted at cycle t → `dout`=1 and `busy`=1 at t+1.
- With `en` high every cycle:
  - `dout` reaches all ones N_LIGHTS−1 ticks after the start.
  - Total ticks from `dout`=1 until `dout`=0 is N_LIGHTS + 1 + D, where D is the latched `delay_val`.
- `lights_out` is high in the same cycle that `dout` first reads 0 in OUT.
- `react_valid` is high in the first DONE cycle; `react_time` is valid from that cycle onward.
- Registered outputs: `dout`, `busy`, the flags and `react_time` all change one clock after the deciding edge. There is no combinational input-to-output path.
- `en` low stalls FILL, HOLD and the reaction count; `react` is still sampled.

## Structure
- Package `f1_pkg` contains:
  - the state enum typedef `f1_state_t`;
  - default parameter constants `F1_N_LIGHTS`, `F1_DELAY_W`, `F1_REACT_W`.
- Sub-module `f1_sat_counter`, parametrised width, with clear/enable and a saturation flag. It is instanced for `react_cnt`.
- `light_cnt` and `hold_cnt` stay inline.
- `dout` is built as a thermometer code from `light_cnt`.

## Test plan
- Nominal run: N_LIGHTS=8, `delay_val`=3, `en`=1 always, `trigger` pulsed at cycle 0 → `dout` = 0x01, 0x03, … 0xFF over cycles 1–8; 0xFF held through cycle 12; `dout`=0 and `lights_out`=1 at cycle 13.
- Reaction: continue the nominal run, `react`=1 at cycle 18 → `react_valid` at 19 with `react_time`=5, `jump_start`=0, `timeout`=0.
- Jump start: `react`=1 at cycle 10 (in HOLD) → DONE at 11, `jump_start`=1, `dout`=0, `lights_out` never pulses.
- Timeout: REACT_W=4, no `react` → DONE with `timeout`=1 and `react_time`=15, 15 ticks after entering OUT.
- Stall and parameters: N_LIGHTS=5, `delay_val`=0, `en` every 3rd cycle → 5 fill steps and 1 hold tick, with no advance on non-`en` cycles. `trigger` held high during FILL has no effect.
- Reset mid-HOLD: `rst`=0 → `dout`, `busy` and all flags are 0 in the same cycle. After release, state is IDLE and a new `trigger` restarts from `dout`=0x01.

Source files
------------

// File: rtl/f1_pkg.sv
// f1_pkg: shared definitions for the F1 start-light sequencer.
//   f1_state_t  - sequencer state encoding (also exposed on the debug port)
//   F1_*        - default values for the sequencer parameters
package f1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_HOLD = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } f1_state_t;

    localparam int F1_N_LIGHTS = 8;
    localparam int F1_DELAY_W  = 7;
    localparam int F1_REACT_W  = 12;

endpackage

// File: rtl/f1_start_seq_if.sv
// f1_start_seq_if: groups the sequencer control inputs and result outputs.
//   Inputs to the sequencer : en, trigger, delay_val, react
//   Outputs of the sequencer: dout, busy, lights_out, react_valid,
//                             react_time, jump_start, timeout
// Handshake: en is a one-cycle strobe that qualifies every sequencing step;
// trigger and react are levels sampled on every clock; lights_out and
// react_valid are one-cycle pulses, and react_time/jump_start/timeout are
// valid from the react_valid cycle until the next accepted start.
interface f1_start_seq_if #(
    parameter int N_LIGHTS = 8,
    parameter int DELAY_W  = 7,
    parameter int REACT_W  = 12
);
    logic                en;
    logic                trigger;
    logic [DELAY_W-1:0]  delay_val;
    logic                react;
    logic [N_LIGHTS-1:0] dout;
    logic                busy;
    logic                lights_out;
    logic                react_valid;
    logic [REACT_W-1:0]  react_time;
    logic                jump_start;
    logic                timeout;

    // Stimulus / consumer side.
    modport master (
        output en, trigger, delay_val, react,
        input  dout, busy, lights_out, react_valid, react_time, jump_start, timeout
    );

    // Sequencer side.
    modport slave (
        input  en, trigger, delay_val, react,
        output dout, busy, lights_out, react_valid, react_time, jump_start, timeout
    );
endinterface

// File: rtl/f1_sat_counter.sv
// f1_sat_counter: W-bit up counter that sticks at its maximum value.
//   clk, rst : clock, asynchronous active-low reset
//   clr_i    : synchronous clear (wins over inc_i)
//   inc_i    : increment request, ignored once saturated
//   cnt_o    : current count
//   sat_o    : high while the count is all ones
module f1_sat_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat_o = &cnt_q;
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/f1_start_seq.sv
// f1_start_seq: F1 start-light sequencer.
// Fills the lamp bar one lamp per tick, holds all lamps on for the latched
// delay, turns them off and counts ticks until the driver reacts. A reaction
// during FILL/HOLD is a jump start; a saturated reaction count is a timeout.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : f1_start_seq_if.slave (control inputs, lamp bar, results)
//   dbg_state_o : current sequencer state
// All outputs are registered.
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int N_LIGHTS = F1_N_LIGHTS,
    parameter int DELAY_W  = F1_DELAY_W,
    parameter int REACT_W  = F1_REACT_W
) (
    input  logic           clk,
    input  logic           rst,
    f1_start_seq_if.slave  bus,
    output f1_state_t      dbg_state_o
);
    localparam int LCNT_W = $clog2(N_LIGHTS + 1);

    f1_state_t           state_q;
    logic [LCNT_W-1:0]   light_cnt_q;
    logic [DELAY_W-1:0]  hold_cnt_q;
    logic [N_LIGHTS-1:0] dout_q;
    logic                busy_q;
    logic                lights_out_q;
    logic                react_valid_q;
    logic [REACT_W-1:0]  react_time_q;
    logic                jump_start_q;
    logic                timeout_q;

    logic [REACT_W-1:0]  react_cnt;
    logic                react_sat;
    logic                react_clr;
    logic                react_inc;
    logic                jump_c;
    logic                hold_exp_c;
    logic [LCNT_W-1:0]   light_cnt_nx;

    // Lower n lamps lit.
    function automatic logic [N_LIGHTS-1:0] therm(input logic [LCNT_W-1:0] n);
        logic [N_LIGHTS-1:0] v;
        v = '0;
        for (int i = 0; i < N_LIGHTS; i++) begin
            if (i < int'(n)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // A reaction while lamps are still lit overrides any same-cycle tick.
    assign jump_c       = ((state_q == ST_FILL) || (state_q == ST_HOLD)) && bus.react;
    assign hold_exp_c   = (state_q == ST_HOLD) && bus.en && !bus.react && (hold_cnt_q == '0);
    assign light_cnt_nx = light_cnt_q + LCNT_W'(1);

    // The reaction counter is cleared on the edge that enters OUT, so it
    // reads 0 in the first OUT cycle.
    assign react_clr = hold_exp_c;
    assign react_inc = (state_q == ST_OUT) && bus.en;

    f1_sat_counter #(.W(REACT_W)) u_react_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (react_clr),
        .inc_i (react_inc),
        .cnt_o (react_cnt),
        .sat_o (react_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            light_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            dout_q        <= '0;
            busy_q        <= 1'b0;
            lights_out_q  <= 1'b0;
            react_valid_q <= 1'b0;
            react_time_q  <= '0;
            jump_start_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            lights_out_q  <= 1'b0;
            react_valid_q <= 1'b0;
            if (jump_c) begin
                state_q       <= ST_DONE;
                dout_q        <= '0;
                busy_q        <= 1'b0;
                react_valid_q <= 1'b1;
                react_time_q  <= '0;
                jump_start_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (bus.trigger) begin
                            state_q      <= ST_FILL;
                            light_cnt_q  <= LCNT_W'(1);
                            hold_cnt_q   <= bus.delay_val;
                            dout_q       <= therm(LCNT_W'(1));
                            busy_q       <= 1'b1;
                            react_time_q <= '0;
                            jump_start_q <= 1'b0;
                            timeout_q    <= 1'b0;
                        end
                    end
                    ST_FILL: begin
                        if (bus.en) begin
                            if (light_cnt_q == LCNT_W'(N_LIGHTS)) begin
                                state_q <= ST_HOLD;
                                dout_q  <= '1;
                            end else begin
                                light_cnt_q <= light_cnt_nx;
                                dout_q      <= therm(light_cnt_nx);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_exp_c) begin
                            state_q      <= ST_OUT;
                            dout_q       <= '0;
                            lights_out_q <= 1'b1;
                        end else if (bus.en) begin
                            hold_cnt_q <= hold_cnt_q - DELAY_W'(1);
                        end
                    end
                    ST_OUT: begin
                        // react_cnt here is the pre-increment value.
                        if (bus.react) begin
                            state_q       <= ST_DONE;
                            busy_q        <= 1'b0;
                            react_valid_q <= 1'b1;
                            react_time_q  <= react_cnt;
                        end else if (bus.en && react_sat) begin
                            state_q       <= ST_DONE;
                            busy_q        <= 1'b0;
                            react_valid_q <= 1'b1;
                            react_time_q  <= react_cnt;
                            timeout_q     <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        dout_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.busy        = busy_q;
    assign bus.lights_out  = lights_out_q;
    assign bus.react_valid = react_valid_q;
    assign bus.react_time  = react_time_q;
    assign bus.jump_start  = jump_start_q;
    assign bus.timeout     = timeout_q;
    assign dbg_state_o     = state_q;
endmodule
